pipe_execute_stage: RTL and testbench

//  Parametrised, registered execute stage for the pipelined ARM-subset CPU; successor to the single-cycle datapath.

---
 rtl/pipe_execute_stage_if.sv | 38 +++
 rtl/pipe_execute_stage.sv | 136 +++++++++++++
 tb/tb_pipe_execute_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_execute_stage_if.sv
// ID/EX -> EX/MEM bus for pipe_execute_stage: decoded operands and controls in,
// registered EX/MEM slot and architectural flags out.
interface pipe_execute_stage_if #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5
);
  logic              in_valid, in_ready, stall, flush;
  logic [REG_AW-1:0] rn_addr, rm_addr, rd_addr, wb_addr;
  logic [DATA_W-1:0] rn_data, rm_data, wb_data;
  logic [25:0]       imm_field;
  logic [1:0]        alu_src;
  logic [2:0]        alu_op;
  logic              set_flags, movz, movk;
  logic              reg_we, mem_we, mem_re, mem_to_reg, wb_we;
  logic              out_valid;
  logic [DATA_W-1:0] out_result, out_store;
  logic [REG_AW-1:0] out_rd;
  logic              out_reg_we, out_mem_we, out_mem_re, out_mem_to_reg, out_zero;
  logic              flag_n, flag_z, flag_v, flag_c;

  modport master (
    output in_valid, stall, flush, rn_addr, rm_addr, rd_addr, rn_data, rm_data,
           imm_field, alu_src, alu_op, set_flags, movz, movk,
           reg_we, mem_we, mem_re, mem_to_reg, wb_we, wb_addr, wb_data,
    input  in_ready, out_valid, out_result, out_store, out_rd, out_reg_we,
           out_mem_we, out_mem_re, out_mem_to_reg, out_zero,
           flag_n, flag_z, flag_v, flag_c
  );

  modport slave (
    input  in_valid, stall, flush, rn_addr, rm_addr, rd_addr, rn_data, rm_data,
           imm_field, alu_src, alu_op, set_flags, movz, movk,
           reg_we, mem_we, mem_re, mem_to_reg, wb_we, wb_addr, wb_data,
    output in_ready, out_valid, out_result, out_store, out_rd, out_reg_we,
           out_mem_we, out_mem_re, out_mem_to_reg, out_zero,
           flag_n, flag_z, flag_v, flag_c
  );
endinterface

// File: rtl/pipe_execute_stage.sv
// Registered execute stage: ALU / MOVZ / MOVK, N/Z/V/C flag register, EX/MEM slot.
// Define EX_FORWARD_EN to forward EX/MEM and writeback results onto operands A/B.
module pipe_execute_stage #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5
) (
  input logic                clk,
  input logic                reset,
  pipe_execute_stage_if.slave ex
);
  localparam int LANES = DATA_W / 16;
  localparam int MSB   = DATA_W - 1;
  localparam logic [REG_AW-1:0] XZR = '1;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store;
    logic [REG_AW-1:0] rd;
    logic              reg_we, mem_we, mem_re, mem_to_reg, zero;
  } exmem_t;

  exmem_t            exm_q, exm_d;
  logic [3:0]        nzvc_q;
  logic [DATA_W-1:0] op_a, op_m, op_b, res_alu, res;
  logic [DATA_W:0]   sum;
  logic              c_alu, v_alu, slot;

  wire [11:0] imm12  = ex.imm_field[21:10];
  wire [8:0]  daddr9 = ex.imm_field[20:12];
  wire [15:0] imm16  = ex.imm_field[20:5];
  wire [1:0]  shamt  = ex.imm_field[22:21];
  logic unused_imm;
  assign unused_imm = ^{ex.imm_field[25:23], ex.imm_field[4:0]};

`ifdef EX_FORWARD_EN
  // Youngest producer wins; loads in EX/MEM have no value yet and are skipped.
  function automatic logic [DATA_W-1:0] src(
    input logic [REG_AW-1:0] a, input logic [DATA_W-1:0] rf, input exmem_t q,
    input logic wwe, input logic [REG_AW-1:0] wa, input logic [DATA_W-1:0] wd);
    if (a == XZR)                                               return '0;
    if (q.valid && q.reg_we && !q.mem_to_reg && q.rd == a)      return q.result;
    if (wwe && wa == a)                                         return wd;
    return rf;
  endfunction

  assign op_a = src(ex.rn_addr, ex.rn_data, exm_q, ex.wb_we, ex.wb_addr, ex.wb_data);
  assign op_m = src(ex.rm_addr, ex.rm_data, exm_q, ex.wb_we, ex.wb_addr, ex.wb_data);
`else
  logic unused_wb;
  assign unused_wb = ^{ex.wb_we, ex.wb_addr, ex.wb_data};
  assign op_a = (ex.rn_addr == XZR) ? '0 : ex.rn_data;
  assign op_m = (ex.rm_addr == XZR) ? '0 : ex.rm_data;
`endif

  always_comb begin
    op_b = '0;
    case (ex.alu_src)
      2'b00:   op_b = op_m;
      2'b01:   op_b = {{(DATA_W-9){daddr9[8]}}, daddr9};
      2'b10:   op_b = {{(DATA_W-12){imm12[11]}}, imm12};
      default: op_b = '0;
    endcase
  end

  always_comb begin
    sum     = '0;
    res_alu = op_b;
    c_alu   = 1'b0;
    v_alu   = 1'b0;
    case (ex.alu_op)
      3'b010: begin
        sum     = {1'b0, op_a} + {1'b0, op_b};
        res_alu = sum[MSB:0];
        c_alu   = sum[DATA_W];
        v_alu   = (op_a[MSB] == op_b[MSB]) && (res_alu[MSB] != op_a[MSB]);
      end
      3'b011: begin
        sum     = {1'b0, op_a} + {1'b0, ~op_b} + {{DATA_W{1'b0}}, 1'b1};
        res_alu = sum[MSB:0];
        c_alu   = sum[DATA_W];
        v_alu   = (op_a[MSB] != op_b[MSB]) && (res_alu[MSB] != op_a[MSB]);
      end
      3'b100:  res_alu = op_a & op_b;
      3'b101:  res_alu = op_a | op_b;
      3'b110:  res_alu = op_a ^ op_b;
      default: res_alu = op_b;
    endcase
  end

  // A shamt beyond the top lane selects no lane: MOVZ gives 0, MOVK keeps rm.
  logic [LANES-1:0][15:0] mov_lanes;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign mov_lanes[l] = (32'(shamt) == l) ? imm16
                        : (ex.movk ? op_m[16*l +: 16] : 16'h0);
  end

  assign res  = (ex.movz || ex.movk) ? mov_lanes : res_alu;
  assign slot = ex.in_valid && !ex.flush;

  always_comb begin
    exm_d            = '0;
    exm_d.valid      = slot;
    exm_d.result     = res;
    exm_d.store      = op_m;
    exm_d.rd         = ex.rd_addr;
    exm_d.reg_we     = ex.reg_we && slot;
    exm_d.mem_we     = ex.mem_we && slot;
    exm_d.mem_re     = ex.mem_re && slot;
    exm_d.mem_to_reg = ex.mem_to_reg && slot;
    exm_d.zero       = (res == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exm_q  <= '0;
      nzvc_q <= '0;
    end else if (!ex.stall) begin
      exm_q <= exm_d;
      if (slot && ex.set_flags && !ex.movz && !ex.movk)
        nzvc_q <= {res_alu[MSB], res_alu == '0, v_alu, c_alu};
    end
  end

  assign ex.in_ready       = !ex.stall;
  assign ex.out_valid      = exm_q.valid;
  assign ex.out_result     = exm_q.result;
  assign ex.out_store      = exm_q.store;
  assign ex.out_rd         = exm_q.rd;
  assign ex.out_reg_we     = exm_q.reg_we;
  assign ex.out_mem_we     = exm_q.mem_we;
  assign ex.out_mem_re     = exm_q.mem_re;
  assign ex.out_mem_to_reg = exm_q.mem_to_reg;
  assign ex.out_zero       = exm_q.zero;
  assign {ex.flag_n, ex.flag_z, ex.flag_v, ex.flag_c} = nzvc_q;
endmodule

// File: tb/tb_pipe_execute_stage.sv
// Directed scoreboard bench for pipe_execute_stage: driver queues hand-computed
// EX/MEM results, a monitor pops and compares whenever a captured slot is valid.
module tb_pipe_execute_stage;
  localparam int DW = 64;
  localparam int AW = 5;

  logic clk, reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_execute_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();
  pipe_execute_stage #(.DATA_W(DW), .REG_AW(AW)) dut (.clk(clk), .reset(reset), .ex(bus.slave));

  typedef struct {
    logic [DW-1:0] res, store;
    logic [AW-1:0] rd;
    logic [3:0]    ctl;
    logic          zero;
    logic [3:0]    nzvc;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;
  logic [3:0] fl = 4'b0000;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [25:0] f_imm12(input logic [11:0] v); return {4'b0, v, 10'b0}; endfunction
  function automatic logic [25:0] f_d9(input logic [8:0] v);     return {5'b0, v, 12'b0}; endfunction
  function automatic logic [25:0] f_mov(input logic [15:0] v, input logic [1:0] s);
    return {3'b0, s, v, 5'b0};
  endfunction

  task automatic idle();
    bus.in_valid = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.rn_addr = 5'd1; bus.rm_addr = 5'd2; bus.rd_addr = 5'd10;
    bus.rn_data = '0; bus.rm_data = '0; bus.imm_field = '0;
    bus.alu_src = 2'b00; bus.alu_op = 3'b010; bus.set_flags = 1'b0;
    bus.movz = 1'b0; bus.movk = 1'b0; bus.reg_we = 1'b1;
    bus.mem_we = 1'b0; bus.mem_re = 1'b0; bus.mem_to_reg = 1'b0;
    bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
  endtask

  // Inputs are already on the bus; queue the expectation and clock once.
  task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] st,
                      input logic upd, input logic [3:0] f);
    exp_t e;
    if (bus.in_valid && !bus.flush && !bus.stall) begin
      if (upd) fl = f;
      e.res = r; e.store = st; e.rd = bus.rd_addr;
      e.ctl = {bus.reg_we, bus.mem_we, bus.mem_re, bus.mem_to_reg};
      e.zero = (r == '0); e.nzvc = fl;
      q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    logic cap;
    exp_t e;
    forever begin
      @(posedge clk);
      cap = !bus.stall;
      @(negedge clk);
      if (cap && reset && bus.out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got result %h with empty queue", bus.out_result);
        end else begin
          e = q.pop_front();
          chk("result", bus.out_result, e.res);
          chk("store", bus.out_store, e.store);
          chk("ctl", {bus.out_rd, bus.out_reg_we, bus.out_mem_we, bus.out_mem_re, bus.out_mem_to_reg},
              {e.rd, e.ctl});
          chk("zero", bus.out_zero, e.zero);
          chk("flags", {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c}, e.nzvc);
        end
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_result"}, bus.out_result, 0);
    chk({tag, "_store"}, bus.out_store, 0);
    chk({tag, "_ctl"}, {bus.out_rd, bus.out_reg_we, bus.out_mem_we, bus.out_mem_re,
                        bus.out_mem_to_reg, bus.out_zero}, 0);
    chk({tag, "_flags"}, {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c}, 0);
  endtask

  initial begin : stim
    reset = 1'b0;
    idle();
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    chk("rst_in_ready", bus.in_ready, 1);
    reset = 1'b1;
    idle();

    bus.rn_data = 64'h7FFF_FFFF_FFFF_FFFF; bus.rm_data = 64'd1; bus.set_flags = 1'b1;
    send(64'h8000_0000_0000_0000, 64'd1, 1, 4'b1010);                      // ADDS overflow
    idle(); bus.rn_data = 64'd5; bus.rm_data = 64'd5; bus.alu_op = 3'b011; bus.set_flags = 1'b1;
    send(64'd0, 64'd5, 1, 4'b0101);                                          // SUBS equal
    idle(); bus.rn_data = 64'd10; bus.rm_data = 64'h77; bus.alu_src = 2'b10; bus.imm_field = f_imm12(12'd5);
    send(64'd15, 64'h77, 0, 4'b0000);                                        // ADDI, flags hold
    idle(); bus.rn_data = 64'd10; bus.alu_src = 2'b10; bus.imm_field = f_imm12(12'hFFF);
    send(64'd9, 64'd0, 0, 4'b0000);                                          // ADDI -1
    idle(); bus.rn_data = 64'h100; bus.alu_src = 2'b01; bus.imm_field = f_d9(9'h1F8);
    bus.mem_re = 1'b1; bus.mem_to_reg = 1'b1;
    send(64'hF8, 64'd0, 0, 4'b0000);                                         // LDUR -8
    idle(); bus.rn_data = 64'h200; bus.rm_data = 64'hDEAD; bus.alu_src = 2'b01;
    bus.imm_field = f_d9(9'd8); bus.mem_we = 1'b1; bus.reg_we = 1'b0;
    send(64'h208, 64'hDEAD, 0, 4'b0000);                                     // STUR
    idle(); bus.movz = 1'b1; bus.set_flags = 1'b1; bus.rm_data = '1;
    bus.imm_field = f_mov(16'hBEEF, 2'd2);
    send(64'h0000_BEEF_0000_0000, '1, 0, 4'b0000);                           // MOVZ, no flags
    idle(); bus.movk = 1'b1; bus.rm_data = 64'h1111_2222_3333_4444;
    bus.imm_field = f_mov(16'hBEEF, 2'd2);
    send(64'h1111_BEEF_3333_4444, 64'h1111_2222_3333_4444, 0, 4'b0000);      // MOVK
    idle(); bus.rn_data = 64'hF0; bus.rm_data = 64'h0F; bus.alu_op = 3'b100; bus.set_flags = 1'b1;
    send(64'd0, 64'h0F, 1, 4'b0100);                                         // ANDS clears C
    idle(); bus.rn_data = 64'd3; bus.rm_data = 64'd5; bus.alu_op = 3'b011; bus.set_flags = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFE, 64'd5, 1, 4'b1000);                        // SUBS borrow
    idle(); bus.rn_data = 64'hFF00; bus.rm_data = 64'h0FF0; bus.alu_op = 3'b101;
    send(64'hFFF0, 64'h0FF0, 0, 4'b0000);                                    // ORR
    idle(); bus.rn_data = 64'hFF00; bus.rm_data = 64'h0FF0; bus.alu_op = 3'b110; bus.set_flags = 1'b1;
    send(64'hF0F0, 64'h0FF0, 1, 4'b0000);                                    // EORS
    idle(); bus.rn_addr = 5'd31; bus.rn_data = 64'h1234; bus.rm_data = 64'd5;
    send(64'd5, 64'd5, 0, 4'b0000);                                          // XZR source
    idle(); bus.alu_src = 2'b11; bus.alu_op = 3'b000; bus.rm_data = 64'h9;
    send(64'd0, 64'h9, 0, 4'b0000);                                          // pass zero
    idle(); bus.rn_data = 64'h8000_0000_0000_0000; bus.rm_data = 64'h8000_0000_0000_0000;
    bus.set_flags = 1'b1;
    send(64'd0, 64'h8000_0000_0000_0000, 1, 4'b0111);                        // ADDS neg overflow
    idle(); bus.movz = 1'b1; bus.imm_field = f_mov(16'h1234, 2'd3);
    send(64'h1234_0000_0000_0000, 64'd0, 0, 4'b0000);                        // MOVZ top lane

    idle(); bus.in_valid = 1'b0; bus.mem_we = 1'b1; bus.set_flags = 1'b1;
    send(64'd0, 64'd0, 0, 4'b0000);
    chk("inv_valid", bus.out_valid, 0);
    chk("inv_we", {bus.out_reg_we, bus.out_mem_we}, 0);
    chk("inv_flags", {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c}, 4'b0111);

    idle(); bus.rn_data = 64'd1; bus.rm_data = 64'd1; bus.set_flags = 1'b1;
    send(64'd2, 64'd1, 1, 4'b0000);
    idle(); bus.stall = 1'b1; bus.flush = 1'b1; bus.alu_op = 3'b011; bus.set_flags = 1'b1;
    bus.rn_data = 64'd4; bus.rm_data = 64'd4;
    for (int i = 0; i < 3; i++) begin
      send(64'd0, 64'd0, 0, 4'b0000);
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_result", bus.out_result, 64'd2);
      chk("stall_flags", {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c}, 4'b0000);
      chk("stall_ready", bus.in_ready, 0);
    end
    bus.stall = 1'b0;
    send(64'd0, 64'd0, 0, 4'b0000);
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_we", bus.out_reg_we, 0);
    chk("flush_flags", {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c}, 4'b0000);

    idle(); bus.rn_data = 64'd0; bus.rm_data = 64'd1; bus.alu_op = 3'b011; bus.set_flags = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 4'b1000);
    idle(); bus.in_valid = 1'b0;
    chk("pre_rst_valid", bus.out_valid, 1);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk_reset("midrst");
    @(posedge clk); #1;
    reset = 1'b1;
    fl = 4'b0000;
    idle(); bus.rn_data = 64'd2; bus.rm_data = 64'd3;
    send(64'd5, 64'd3, 0, 4'b0000);

`ifdef EX_FORWARD_EN
    idle(); bus.rn_addr = 5'd31; bus.rn_data = 64'h99; bus.rd_addr = 5'd1;
    bus.alu_src = 2'b10; bus.imm_field = f_imm12(12'd7);
    send(64'd7, 64'd0, 0, 4'b0000);                                          // ADDI X1=X31+7
    idle(); bus.rn_addr = 5'd1; bus.rm_addr = 5'd1; bus.rd_addr = 5'd2;
    bus.wb_we = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 64'd100;
    send(64'd14, 64'd7, 0, 4'b0000);                                         // EX/MEM beats WB
    idle(); bus.rn_addr = 5'd31; bus.rm_addr = 5'd31; bus.rd_addr = 5'd5;
    bus.wb_we = 1'b1; bus.wb_addr = 5'd31; bus.wb_data = 64'd55;
    send(64'd0, 64'd0, 0, 4'b0000);                                          // XZR never forwarded
    idle(); bus.rn_addr = 5'd4; bus.rd_addr = 5'd6; bus.alu_src = 2'b10; bus.imm_field = f_imm12(12'd1);
    bus.wb_we = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 64'd20;
    send(64'd21, 64'd0, 0, 4'b0000);                                         // WB forward
    idle(); bus.rn_addr = 5'd4; bus.rn_data = 64'h40; bus.rd_addr = 5'd7; bus.alu_src = 2'b01;
    bus.mem_re = 1'b1; bus.mem_to_reg = 1'b1;
    send(64'h40, 64'd0, 0, 4'b0000);
    idle(); bus.rn_addr = 5'd7; bus.rn_data = 64'd3; bus.rd_addr = 5'd8; bus.alu_src = 2'b10;
    send(64'd3, 64'd0, 0, 4'b0000);                                          // load not forwarded
`endif

    idle(); bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
